// File: rtl/conv1d_k4.sv
// Four-channel, four-tap 1-D convolution with one shared multiplier and saturating Q(W-D).D output.
// Define CONV1D_RELU_EN to clamp negative channel results to zero.
module conv1d_k4 #(
  parameter int W = 16,
  parameter int D = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic signed [W-1:0] in_d0,
  input  logic signed [W-1:0] in_d1,
  input  logic signed [W-1:0] in_d2,
  input  logic signed [W-1:0] in_d3,
  input  logic                wr_en,
  input  logic [3:0]          wr_addr,
  input  logic signed [W-1:0] wr_data,
  output logic signed [W-1:0] out_c0,
  output logic signed [W-1:0] out_c1,
  output logic signed [W-1:0] out_c2,
  output logic signed [W-1:0] out_c3,
  output logic                busy,
  output logic                out_valid
);

  localparam int PW = 2 * W;
  localparam int AW = 2 * W + 2;

  localparam logic signed [W-1:0]  ONE     = W'(1) << D;
  localparam logic signed [AW-1:0] SAT_MAX = {{(W + 3){1'b0}}, {(W - 1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(W + 3){1'b1}}, {(W - 1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    STORE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [1:0]           c_q, c_d;
  logic [1:0]           k_q, k_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [W-1:0]  tap_q [4];
  logic signed [W-1:0]  tap_d [4];
  logic signed [W-1:0]  w_q   [16];
  logic signed [W-1:0]  w_d   [16];
  logic signed [W-1:0]  out_q [4];
  logic signed [W-1:0]  out_d [4];

  logic signed [W-1:0]  tap_sel;
  logic signed [W-1:0]  w_sel;
  logic [PW-1:0]        product;
  logic signed [AW-1:0] product_ext;
  logic signed [AW-1:0] shifted;
  logic signed [W-1:0]  sat_val;
  logic signed [W-1:0]  store_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = MAC;
      MAC:     if (k_q == 2'd3) state_d = STORE;
      STORE:   state_d = (c_q == 2'd3) ? DONE : MAC;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    out_valid = (state_q == DONE);
  end

  // Operands are sign-extended to 2W so the truncated product is the exact signed result.
  always_comb begin
    tap_sel     = tap_q[k_q];
    w_sel       = w_q[{c_q, k_q}];
    product     = {{W{tap_sel[W-1]}}, tap_sel} * {{W{w_sel[W-1]}}, w_sel};
    product_ext = {{2{product[PW-1]}}, product};
    shifted     = acc_q >>> D;
  end

  always_comb begin
    if (shifted > SAT_MAX) begin
      sat_val = SAT_MAX[W-1:0];
    end else if (shifted < SAT_MIN) begin
      sat_val = SAT_MIN[W-1:0];
    end else begin
      sat_val = shifted[W-1:0];
    end
`ifdef CONV1D_RELU_EN
    store_val = sat_val[W-1] ? '0 : sat_val;
`else
    store_val = sat_val;
`endif
  end

  always_comb begin
    c_d   = c_q;
    k_d   = k_q;
    acc_d = acc_q;
    tap_d = tap_q;
    w_d   = w_q;
    out_d = out_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          tap_d[0] = in_d0;
          tap_d[1] = in_d1;
          tap_d[2] = in_d2;
          tap_d[3] = in_d3;
          acc_d    = '0;
          c_d      = 2'd0;
          k_d      = 2'd0;
        end
        // Weight writes land at the same edge that latches the taps, so the pass sees them.
        if (wr_en) begin
          w_d[wr_addr] = wr_data;
        end
      end
      MAC: begin
        acc_d = acc_q + product_ext;
        if (k_q != 2'd3) begin
          k_d = k_q + 2'd1;
        end
      end
      STORE: begin
        out_d[c_q] = store_val;
        acc_d      = '0;
        k_d        = 2'd0;
        if (c_q != 2'd3) begin
          c_d = c_q + 2'd1;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_q   <= 2'd0;
      k_q   <= 2'd0;
      acc_q <= '0;
      for (int i = 0; i < 4; i++) begin
        tap_q[i] <= '0;
        out_q[i] <= '0;
      end
      // Diagonal weights start at 1.0 so each channel passes its own tap through.
      for (int i = 0; i < 16; i++) begin
        w_q[i] <= (i % 5 == 0) ? ONE : '0;
      end
    end else begin
      c_q   <= c_d;
      k_q   <= k_d;
      acc_q <= acc_d;
      tap_q <= tap_d;
      w_q   <= w_d;
      out_q <= out_d;
    end
  end

  assign out_c0 = out_q[0];
  assign out_c1 = out_q[1];
  assign out_c2 = out_q[2];
  assign out_c3 = out_q[3];

endmodule

// File: tb/tb_conv1d_k4.sv
// Directed bench for conv1d_k4: identity, weight writes, saturation, busy-time
// hazards and mid-pass reset, with hand-computed expected results.
module tb_conv1d_k4;

  localparam int W = 16;

  logic                clk;
  logic                rst;
  logic                start;
  logic signed [W-1:0] in_d0, in_d1, in_d2, in_d3;
  logic                wr_en;
  logic [3:0]          wr_addr;
  logic signed [W-1:0] wr_data;
  logic signed [W-1:0] out_c0, out_c1, out_c2, out_c3;
  logic                busy;
  logic                out_valid;

  int n_checks = 0;
  int n_pass   = 0;
  int latency, pulses, busy_err;

  conv1d_k4 #(.W(W), .D(12)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_d0     (in_d0),
    .in_d1     (in_d1),
    .in_d2     (in_d2),
    .in_d3     (in_d3),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .out_c0    (out_c0),
    .out_c1    (out_c1),
    .out_c2    (out_c2),
    .out_c3    (out_c3),
    .busy      (busy),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic signed [31:0] obs,
                              input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic check_outs(input string tag, input int e0, input int e1,
                            input int e2, input int e3);
    check_output({tag, "_c0"}, out_c0, e0);
    check_output({tag, "_c1"}, out_c1, e1);
    check_output({tag, "_c2"}, out_c2, e2);
    check_output({tag, "_c3"}, out_c3, e3);
  endtask

  task automatic write_w(input logic [3:0] addr, input logic signed [W-1:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    tick();
    wr_en   = 1'b0;
  endtask

  // Starts one pass and watches it for a bounded number of cycles; the
  // *_cyc arguments inject start / weight write / reset / tap change at that cycle.
  task automatic apply_stimulus(input logic signed [W-1:0] d0, input logic signed [W-1:0] d1,
                                input logic signed [W-1:0] d2, input logic signed [W-1:0] d3,
                                input int start_cyc, input int wr_cyc, input int rst_cyc,
                                input int tap_cyc, output int lat, output int npulse,
                                output int berr);
    logic exp_busy;
    in_d0 = d0;
    in_d1 = d1;
    in_d2 = d2;
    in_d3 = d3;
    start = 1'b1;
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    lat    = -1;
    npulse = 0;
    berr   = 0;
    for (int cyc = 1; cyc <= 50; cyc++) begin
      if (out_valid) begin
        npulse++;
        if (lat < 0) lat = cyc;
      end
      exp_busy = (cyc <= 21) && (rst_cyc == 0 || cyc <= rst_cyc);
      if (busy !== exp_busy) berr++;
      start   = (cyc == start_cyc);
      wr_en   = (cyc == wr_cyc);
      wr_addr = 4'd0;
      wr_data = '0;
      rst     = (cyc == rst_cyc);
      if (cyc == tap_cyc) begin
        in_d0 = 16'sh2222;
        in_d1 = 16'sh2222;
        in_d2 = 16'sh2222;
        in_d3 = 16'sh2222;
      end
      tick();
    end
    start = 1'b0;
    wr_en = 1'b0;
    rst   = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    in_d0   = '0;
    in_d1   = '0;
    in_d2   = '0;
    in_d3   = '0;
    tick();
    tick();
    rst = 1'b0;

    $display("[TB] reset state");
    check_outs("reset", 0, 0, 0, 0);
    check_output("reset_busy", busy, 0);
    check_output("reset_valid", out_valid, 0);

    $display("[TB] identity pass");
    apply_stimulus(100, 200, 300, 400, 0, 0, 0, 0, latency, pulses, busy_err);
    check_output("ident_latency", latency, 21);
    check_output("ident_pulses", pulses, 1);
    check_output("ident_busy_err", busy_err, 0);
    check_outs("ident", 100, 200, 300, 400);

    $display("[TB] channel 0 sums all taps, last weight written with start");
    write_w(4'd0, 16'sh1000);
    write_w(4'd1, 16'sh1000);
    write_w(4'd2, 16'sh1000);
    wr_en   = 1'b1;
    wr_addr = 4'd3;
    wr_data = 16'sh1000;
    apply_stimulus(250, 250, 250, 250, 0, 0, 0, 0, latency, pulses, busy_err);
    check_outs("sum", 1000, 250, 250, 250);

    $display("[TB] saturation");
    write_w(4'd0, 16'sh7FFF);
    write_w(4'd1, 16'sh7FFF);
    write_w(4'd2, 16'sh7FFF);
    write_w(4'd3, 16'sh7FFF);
    apply_stimulus(32767, 32767, 32767, 32767, 0, 0, 0, 0, latency, pulses, busy_err);
    check_outs("sat_pos", 32767, 32767, 32767, 32767);
    apply_stimulus(-32768, -32768, -32768, -32768, 0, 0, 0, 0, latency, pulses, busy_err);
`ifdef CONV1D_RELU_EN
    check_outs("sat_neg", 0, 0, 0, 0);
`else
    check_outs("sat_neg", -32768, -32768, -32768, -32768);
`endif

    $display("[TB] start, weight write and tap change while busy");
    apply_stimulus(10, 20, 30, 40, 5, 7, 0, 3, latency, pulses, busy_err);
    check_output("busy_latency", latency, 21);
    check_output("busy_pulses", pulses, 1);
    check_output("busy_busy_err", busy_err, 0);
    check_outs("busy", 799, 20, 30, 40);
    apply_stimulus(1, 2, 3, 4, 0, 0, 0, 0, latency, pulses, busy_err);
    check_outs("wkeep", 79, 2, 3, 4);

    $display("[TB] reset mid-pass");
    apply_stimulus(5, 6, 7, 8, 0, 0, 10, 0, latency, pulses, busy_err);
    check_output("abort_pulses", pulses, 0);
    check_output("abort_busy_err", busy_err, 0);
    check_output("abort_valid", out_valid, 0);
    check_outs("abort", 0, 0, 0, 0);
    apply_stimulus(-7, 8, -9, 10, 0, 0, 0, 0, latency, pulses, busy_err);
    check_output("fresh_latency", latency, 21);
    check_output("fresh_pulses", pulses, 1);
`ifdef CONV1D_RELU_EN
    check_outs("fresh", 0, 8, 0, 10);
`else
    check_outs("fresh", -7, 8, -9, 10);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
